// File: rtl/water_level_matrix_scanner.sv
// ============================================================================
// Module   : water_level_matrix_scanner
// Brief    : Latches a water level once per frame and column-scans a
//            ROWS x COLS LED matrix showing a tank: wall columns fully lit,
//            inner columns lit bottom-up in proportion to the level.
//            Optional macro WATER_LEVEL_CRITICAL_BLINK_EN blinks the water
//            and walls while the latched level is critical (0).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module water_level_matrix_scanner #(
  parameter int ROWS         = 7,
  parameter int COLS         = 5,
  parameter int LEVEL_W      = 2,
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 50,
  parameter bit ACTIVE_LOW   = 1'b0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic [LEVEL_W-1:0] level,
  output logic [COLS-1:0]    col_sel,
  output logic [ROWS-1:0]    row_data,
  output logic               frame_start
);

  localparam int c_levels = 2 ** LEVEL_W;
  localparam int c_div_w  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int c_col_w  = $clog2(COLS);
  localparam int c_fill_w = $clog2(ROWS + 1);
  localparam int c_prod_w = LEVEL_W + c_fill_w;

  localparam logic [c_div_w-1:0]  c_div_last = c_div_w'(SCAN_DIV - 1);
  localparam logic [c_col_w-1:0]  c_col_last = c_col_w'(COLS - 1);
  localparam logic [COLS-1:0]     c_col_one  = {{(COLS-1){1'b0}}, 1'b1};
  localparam logic [COLS-1:0]     c_col_pol  = {COLS{ACTIVE_LOW}};
  localparam logic [ROWS-1:0]     c_row_pol  = {ROWS{ACTIVE_LOW}};
  localparam logic [c_prod_w-1:0] c_rows_p   = c_prod_w'(ROWS);
  localparam logic [c_prod_w-1:0] c_lvmax_p  = c_prod_w'(c_levels - 1);

  logic [c_div_w-1:0]  r_div_cnt;
  logic [c_col_w-1:0]  r_col_idx;
  logic [LEVEL_W-1:0]  r_level_q;
  logic [COLS-1:0]     r_col_sel;
  logic [ROWS-1:0]     r_row_data;
  logic                r_frame_start;

  logic                w_boundary;
  logic                w_div_wrap;
  logic [LEVEL_W-1:0]  w_level_next;
  logic [c_prod_w-1:0] w_prod;
  logic [c_fill_w-1:0] w_fill;
  logic [ROWS-1:0]     w_water;
  logic                w_is_wall;
  logic [COLS-1:0]     w_col_onehot;
  logic [ROWS-1:0]     w_rows;
  logic                w_hidden;

  // Frame position decode and the level the output stage must draw this cycle
  always_comb begin
    w_boundary   = enable && (r_div_cnt == '0) && (r_col_idx == '0);
    w_div_wrap   = (r_div_cnt == c_div_last);
    w_level_next = w_boundary ? level : r_level_q;
  end

  // Water height: fill = floor(level*ROWS/(LEVELS-1)), lit from the bottom row up
  always_comb begin
    w_prod = c_prod_w'(w_level_next) * c_rows_p;
    w_fill = c_fill_w'(w_prod / c_lvmax_p);
    w_water = '0;
    for (int i = 0; i < ROWS; i++) begin
      w_water[i] = (i >= (ROWS - int'(w_fill)));
    end
  end

  // Image for the column currently indexed (pins lag col_idx by one clock)
  always_comb begin
    w_col_onehot = c_col_one << r_col_idx;
    w_is_wall    = (r_col_idx == '0) || (r_col_idx == c_col_last);
    if (w_hidden) begin
      w_rows = '0;
    end else if (w_is_wall) begin
      w_rows = '1;
    end else begin
      w_rows = w_water;
    end
  end

`ifdef WATER_LEVEL_CRITICAL_BLINK_EN
  localparam int c_blink_w = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [c_blink_w-1:0] c_blink_last = c_blink_w'(BLINK_FRAMES - 1);

  logic [c_blink_w-1:0] r_blink_cnt;
  logic                 r_blink_phase;
  logic                 r_frame_hidden;

  // A frame's visibility is fixed at its boundary from the phase before the count update
  always_comb begin
    w_hidden = w_boundary ? ((level == '0) && r_blink_phase) : r_frame_hidden;
  end

  // Blink counter: counts critical frames, toggles phase every BLINK_FRAMES of them
  always_ff @(posedge clock) begin
    if (reset) begin
      r_blink_cnt    <= '0;
      r_blink_phase  <= 1'b0;
      r_frame_hidden <= 1'b0;
    end else if (w_boundary) begin
      r_frame_hidden <= (level == '0) && r_blink_phase;
      if (level == '0) begin
        if (r_blink_cnt == c_blink_last) begin
          r_blink_cnt   <= '0;
          r_blink_phase <= ~r_blink_phase;
        end else begin
          r_blink_cnt <= r_blink_cnt + 1'b1;
        end
      end else begin
        r_blink_cnt   <= '0;
        r_blink_phase <= 1'b0;
      end
    end
  end
`else
  assign w_hidden = 1'b0;
`endif

  // Scan divider, column index, per-frame level latch and registered pin drivers
  always_ff @(posedge clock) begin
    if (reset) begin
      r_div_cnt     <= '0;
      r_col_idx     <= '0;
      r_level_q     <= '0;
      r_col_sel     <= c_col_pol;
      r_row_data    <= c_row_pol;
      r_frame_start <= 1'b0;
    end else if (!enable) begin
      r_div_cnt     <= '0;
      r_col_idx     <= '0;
      r_col_sel     <= c_col_pol;
      r_row_data    <= c_row_pol;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_boundary;
      r_level_q     <= w_level_next;
      if (w_div_wrap) begin
        r_div_cnt <= '0;
        r_col_idx <= (r_col_idx == c_col_last) ? '0 : r_col_idx + 1'b1;
      end else begin
        r_div_cnt <= r_div_cnt + 1'b1;
      end
      r_col_sel  <= w_col_onehot ^ c_col_pol;
      r_row_data <= w_rows ^ c_row_pol;
    end
  end

  assign col_sel     = r_col_sel;
  assign row_data    = r_row_data;
  assign frame_start = r_frame_start;

endmodule

`default_nettype wire
